// File: rtl/argmax_classifier.sv
// Serial argmax over a snapshot of output-layer neuron scores; reports the predicted class index.
// Latency: start edge k -> done high in the cycle after edge k+NUM_CLASSES-1 (one compare per clock).
// Backpressure: none; start while busy is ignored. Macro ARGMAX_SCORE_OUT_EN adds the max_score port.
module argmax_classifier #(
    parameter int NUM_CLASSES = 10,
    parameter int NEURON_BITS = 15,
    parameter int IDX_BITS    = 4
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          start,
    input  logic signed [NEURON_BITS+8:0] scores [0:NUM_CLASSES-1],
    output logic                          busy,
    output logic                          done,
    output logic        [IDX_BITS-1:0]    class_idx
`ifdef ARGMAX_SCORE_OUT_EN
    ,
    output logic signed [NEURON_BITS+8:0] max_score
`endif
);

    localparam int SW = NEURON_BITS + 9;
    localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(NUM_CLASSES - 1);

    // A class count outside 2..2**IDX_BITS cannot be indexed by class_idx.
    if (NUM_CLASSES < 2 || NUM_CLASSES > (1 << IDX_BITS)) begin : g_bad_cfg
        $fatal(1, "argmax_classifier: NUM_CLASSES out of range for IDX_BITS");
    end

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t                 state;
    logic signed [SW-1:0]   snap [0:NUM_CLASSES-1];
    logic signed [SW-1:0]   best_val;
    logic [IDX_BITS-1:0]    best_idx;
    logic [IDX_BITS-1:0]    i;

    logic signed [SW-1:0]   cur_val;
    logic signed [SW-1:0]   nxt_val;
    logic [IDX_BITS-1:0]    nxt_idx;

    assign cur_val = snap[i];

    // Running best after this cycle's compare; strictly-greater keeps ties on the lowest index.
    always_comb begin
        nxt_val = best_val;
        nxt_idx = best_idx;
        if (cur_val > best_val) begin
            nxt_val = cur_val;
            nxt_idx = i;
        end
    end

    // Control FSM: snapshot on start, one class per clock, publish result on the last class.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            class_idx <= '0;
            best_val  <= '0;
            best_idx  <= '0;
            i         <= '0;
            for (int c = 0; c < NUM_CLASSES; c++) begin
                snap[c] <= '0;
            end
`ifdef ARGMAX_SCORE_OUT_EN
            max_score <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        for (int c = 0; c < NUM_CLASSES; c++) begin
                            snap[c] <= scores[c];
                        end
                        best_val <= scores[0];
                        best_idx <= '0;
                        i        <= IDX_BITS'(1);
                        busy     <= 1'b1;
                        state    <= SCAN;
                    end
                end
                SCAN: begin
                    best_val <= nxt_val;
                    best_idx <= nxt_idx;
                    if (i == LAST_IDX) begin
                        class_idx <= nxt_idx;
`ifdef ARGMAX_SCORE_OUT_EN
                        max_score <= nxt_val;
`endif
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        i <= i + IDX_BITS'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_argmax_classifier.sv
// Directed bench for argmax_classifier: latency, ties, negatives, snapshot, busy rejection, reset abort.
// Inputs driven on the falling edge, outputs sampled on the falling edge.
// Handles both builds; max_score is checked only when ARGMAX_SCORE_OUT_EN is defined.
module tb_argmax_classifier;

    localparam int NC = 10;
    localparam int NB = 15;
    localparam int IB = 4;
    localparam int SW = NB + 9;

    logic                 clk = 1'b0;
    logic                 rstn;
    logic                 start;
    logic signed [SW-1:0] scores [0:NC-1];
    logic                 busy;
    logic                 done;
    logic [IB-1:0]        class_idx;
`ifdef ARGMAX_SCORE_OUT_EN
    logic signed [SW-1:0] max_score;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    argmax_classifier #(.NUM_CLASSES(NC), .NEURON_BITS(NB), .IDX_BITS(IB)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .start     (start),
        .scores    (scores),
        .busy      (busy),
        .done      (done),
        .class_idx (class_idx)
`ifdef ARGMAX_SCORE_OUT_EN
        ,
        .max_score (max_score)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic load(input int v[NC]);
        for (int c = 0; c < NC; c++) begin
            scores[c] = v[c][SW-1:0];
        end
    endtask

    task automatic check_max(input string tag, input longint exp);
`ifdef ARGMAX_SCORE_OUT_EN
        chk(tag, max_score, exp);
`else
        if (tag.len() == 0 && exp == 0) begin
            $display("unused");
        end
`endif
    endtask

    // Pulse start from a falling edge, then step falling edges until done (bounded).
    // ev_kind at step ev_at: 1 = zero all scores, 2 = pulse start again, 3 = assert reset.
    task automatic run_scan(input int ev_at, input int ev_kind,
                            output int edges, output int busy_n);
        int cnt;
        cnt    = 0;
        busy_n = 0;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        while (!done && cnt < 40) begin
            start = 1'b0;
            if (busy) busy_n++;
            if (cnt == ev_at) begin
                case (ev_kind)
                    1: for (int c = 0; c < NC; c++) scores[c] = '0;
                    2: start = 1'b1;
                    3: rstn = 1'b0;
                    default: ;
                endcase
            end
            @(negedge clk);
            cnt++;
        end
        start = 1'b0;
        edges = cnt;
    endtask

    initial begin
        int v[NC];
        int edges, busy_n, dn;

        rstn  = 1'b0;
        start = 1'b0;
        for (int c = 0; c < NC; c++) scores[c] = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_idx", class_idx, 0);
        check_max("rst_max", 0);
        rstn = 1'b1;
        @(negedge clk);

        // Basic vector: winner index 2 with score 12.
        v = '{3, -7, 12, 5, 0, 1, -2, 9, 4, 11};
        load(v);
        run_scan(-1, 0, edges, busy_n);
        chk("basic_latency", edges, 9);
        chk("basic_busy_cycles", busy_n, 9);
        chk("basic_idx", class_idx, 2);
        chk("basic_busy_at_done", busy, 0);
        check_max("basic_max", 12);
        @(negedge clk);
        chk("basic_done_width", done, 0);

        // Hold: idle with changing scores, result must not move.
        dn = 0;
        for (int t = 0; t < 20; t++) begin
            for (int c = 0; c < NC; c++) scores[c] = SW'($urandom_range(0, 5000));
            @(negedge clk);
            if (done) dn++;
        end
        chk("hold_done", dn, 0);
        chk("hold_idx", class_idx, 2);
        check_max("hold_max", 12);

        // Tie between idx4 and idx8 resolves to 4.
        v = '{-5, -5, -5, -5, 20, -5, -5, -5, 20, -5};
        load(v);
        run_scan(-1, 0, edges, busy_n);
        chk("tie_latency", edges, 9);
        chk("tie_idx", class_idx, 4);
        check_max("tie_max", 20);

        // All most-negative values.
        for (int c = 0; c < NC; c++) v[c] = -(1 << (SW - 1));
        load(v);
        run_scan(-1, 0, edges, busy_n);
        chk("neg_idx", class_idx, 0);
        check_max("neg_max", -(longint'(1) << (SW - 1)));

        // Last index wins; scores zeroed right after start must not matter.
        v = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1000};
        load(v);
        run_scan(0, 1, edges, busy_n);
        chk("last_latency", edges, 9);
        chk("last_idx", class_idx, 9);
        check_max("last_max", 1000);

        // Second start 3 cycles into the scan is ignored.
        v = '{1, 2, 3, 50, 4, 5, 6, 7, 8, 9};
        load(v);
        run_scan(3, 2, edges, busy_n);
        chk("rej_latency", edges, 9);
        chk("rej_idx", class_idx, 3);
        // Back-to-back: start in the done cycle with winner idx6.
        v = '{10, 20, 30, 40, 50, 60, 700, 70, 80, 90};
        load(v);
        run_scan(-1, 0, edges, busy_n);
        chk("b2b_latency", edges, 9);
        chk("b2b_idx", class_idx, 6);
        check_max("b2b_max", 700);
        @(negedge clk);

        // Reset on the 5th scan cycle aborts the scan without done.
        v = '{3, -7, 12, 5, 0, 1, -2, 9, 4, 11};
        load(v);
        run_scan(4, 3, edges, busy_n);
        chk("abort_no_done", edges, 40);
        chk("abort_busy", busy, 0);
        chk("abort_idx", class_idx, 0);
        check_max("abort_max", 0);
        rstn = 1'b1;
        @(negedge clk);
        run_scan(-1, 0, edges, busy_n);
        chk("fresh_latency", edges, 9);
        chk("fresh_idx", class_idx, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
